// File: rtl/reg_list_sequencer_if.sv
// Handshake bundle between the instruction decoder (master) and the
// register-list sequencer (slave). Parameters must match the sequencer's.
interface reg_list_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
);
  logic             i_start;
  logic [WIDTH-1:0] i_code;
  logic             i_order;
  logic             i_flush;
  logic             i_ready;
  logic             o_busy;
  logic             o_valid;
  logic [IDX_W-1:0] o_index;
  logic             o_first;
  logic             o_last;
  logic             o_done;
  logic             o_empty;
  logic [IDX_W:0]   o_remaining;

  modport master (
    output i_start, i_code, i_order, i_flush, i_ready,
    input  o_busy, o_valid, o_index, o_first, o_last, o_done, o_empty, o_remaining
  );

  modport slave (
    input  i_start, i_code, i_order, i_flush, i_ready,
    output o_busy, o_valid, o_index, o_first, o_last, o_done, o_empty, o_remaining
  );
endinterface

// File: rtl/reg_list_sequencer.sv
// Register-list sequencer: latches an LDM/STM-style bitmap and emits the index
// of each set bit, one per accepted beat, ascending (LSB first) or descending.
// Optional beat counter on o_remaining: define REG_LIST_SEQUENCER_COUNT_EN.
module reg_list_sequencer #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  reg_list_sequencer_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_map, w_map_nxt;
  logic             r_order, w_order_nxt;
  logic             r_first, w_first_nxt;
  logic             r_done, w_done_nxt;
  logic             r_empty, w_empty_nxt;
  logic [IDX_W-1:0] w_index;
  logic [WIDTH-1:0] w_onehot;
  logic             w_last;

  // Lowest set bit position; the last assignment in the loop wins.
  function automatic logic [IDX_W-1:0] f_lowest(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  // Highest set bit position; the last assignment in the loop wins.
  function automatic logic [IDX_W-1:0] f_highest(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  // Current beat comes straight from the held bitmap, so no extra pipeline stage.
  assign w_index  = r_order ? f_lowest(r_map) : f_highest(r_map);
  assign w_onehot = ONE << w_index;
  // Exactly one bit left: non-zero and clearing the lowest bit leaves nothing.
  assign w_last   = (r_map != '0) && ((r_map & (r_map - ONE)) == '0);

  // Next-state and next-register computation; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_map_nxt   = r_map;
    w_order_nxt = r_order;
    w_first_nxt = r_first;
    w_done_nxt  = 1'b0;
    w_empty_nxt = 1'b0;
    if (bus.i_flush) begin
      w_state_nxt = ST_IDLE;
      w_map_nxt   = '0;
      w_first_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            if (bus.i_code != '0) begin
              w_state_nxt = ST_RUN;
              w_map_nxt   = bus.i_code;
              w_order_nxt = bus.i_order;
              w_first_nxt = 1'b1;
            end else begin
              // Empty list completes immediately without issuing beats.
              w_done_nxt  = 1'b1;
              w_empty_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.i_ready) begin
            w_map_nxt   = r_map & ~w_onehot;
            w_first_nxt = 1'b0;
            if (w_last) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_map_nxt   = '0;
          w_first_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and held-list registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_map   <= '0;
      r_order <= 1'b0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_map   <= w_map_nxt;
      r_order <= w_order_nxt;
      r_first <= w_first_nxt;
      r_done  <= w_done_nxt;
      r_empty <= w_empty_nxt;
    end
  end

  assign bus.o_busy  = (r_state == ST_RUN);
  assign bus.o_valid = (r_state == ST_RUN);
  assign bus.o_index = w_index;
  assign bus.o_first = r_first;
  assign bus.o_last  = w_last;
  assign bus.o_done  = r_done;
  assign bus.o_empty = r_empty;

`ifdef REG_LIST_SEQUENCER_COUNT_EN
  logic [IDX_W:0] r_cnt;
  logic           w_load;
  logic           w_accept;

  // Number of set bits in the incoming list.
  function automatic logic [IDX_W:0] f_popcount(input logic [WIDTH-1:0] m);
    logic [IDX_W:0] c;
    c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      c = c + {{IDX_W{1'b0}}, m[k]};
    end
    return c;
  endfunction

  assign w_load   = (r_state == ST_IDLE) && bus.i_start && !bus.i_flush && (bus.i_code != '0);
  assign w_accept = (r_state == ST_RUN) && bus.i_ready && !bus.i_flush;

  // Beats-left counter; reaches zero exactly when the last beat is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (bus.i_flush) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= f_popcount(bus.i_code);
    end else if (w_accept) begin
      r_cnt <= r_cnt - {{IDX_W{1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bus.o_remaining = r_cnt;
`else
  assign bus.o_remaining = '0;
`endif

endmodule
